// File: rtl/boot_loader_pkg.sv
// Shared widths, default program length and FSM encoding for the boot loader.
package boot_loader_pkg;
  localparam int ADDR_SIZE = 8;
  localparam int WORD_SIZE = 8;
  localparam int BOOT_LEN  = 16;

  typedef enum logic [2:0] {
    COPY_RD = 3'd0,
    COPY_WR = 3'd1,
    VFY_RD  = 3'd2,
    VFY_CMP = 3'd3,
    DONE    = 3'd4
  } boot_state_t;
endpackage

// File: rtl/boot_loader.sv
// Post-reset ROM->RAM program copier with optional read-back verify; holds the CPU
// until the image is in place. All bus outputs decode from registered state only.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_SIZE,
  parameter int WORD_W   = WORD_SIZE,
  parameter int PROG_LEN = BOOT_LEN,
  parameter int ROM_BASE = 0,
  parameter int RAM_BASE = 0,
  parameter bit VERIFY   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reboot,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_err
);
  localparam int IDX_W = $clog2(PROG_LEN + 1);

  boot_state_t       state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] buffer;
  logic              err;
  logic              last;
  logic [ADDR_W-1:0] rom_ofs, ram_ofs;

  assign last    = (idx == IDX_W'(PROG_LEN - 1));
  // Base + index wraps modulo 2**ADDR_W by truncation.
  assign rom_ofs = ADDR_W'(ROM_BASE) + ADDR_W'(idx);
  assign ram_ofs = ADDR_W'(RAM_BASE) + ADDR_W'(idx);

  always_ff @(posedge clk) begin
    if (rst) state <= COPY_RD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COPY_RD: state_nxt = COPY_WR;
      COPY_WR: if (last) state_nxt = VERIFY ? VFY_RD : DONE;
               else      state_nxt = COPY_RD;
      VFY_RD:  state_nxt = VFY_CMP;
      VFY_CMP: state_nxt = last ? DONE : VFY_RD;
      DONE:    if (reboot) state_nxt = COPY_RD;
      default: state_nxt = COPY_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      buffer <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        COPY_RD: buffer <= rom_data;
        COPY_WR: idx <= last ? '0 : idx + IDX_W'(1);
        VFY_CMP: begin
          if (ram_rdata != rom_data) err <= 1'b1;
          idx <= last ? '0 : idx + IDX_W'(1);
        end
        DONE: if (reboot) begin
          err <= 1'b0;
          idx <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_addr  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    cpu_hold  = 1'b1;
    boot_done = 1'b0;
    case (state)
      COPY_RD: rom_addr = rom_ofs;
      COPY_WR: begin
        ram_addr  = ram_ofs;
        ram_wdata = buffer;
        ram_wr_en = 1'b1;
      end
      VFY_RD: begin
        ram_addr  = ram_ofs;
        ram_rd_en = 1'b1;
      end
      VFY_CMP: rom_addr = rom_ofs;
      DONE: begin
        cpu_hold  = 1'b0;
        boot_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign boot_err = err;
endmodule
